// File: rtl/ad5628_cfg_seq.sv
// ad5628_cfg_seq: AD5628 power-up command sequencer.
// Streams reset, ref-enable and eight channel writes into spi_base.
module ad5628_cfg_seq #(
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_sys,
  input  logic        rst_sys,
  input  logic        start,
  input  logic [95:0] ch_codes,
  input  logic        spi_busy,
  input  logic        spi_done,
  output logic        spi_start,
  output logic [31:0] spi_data,
  output logic        busy,
  output logic        cfg_done,
  output logic        err,
  output logic [3:0]  word_idx
);

  localparam logic [7:0]  GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam logic [15:0] TMO_LIM  = 16'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_GAP,
    S_FINISH
  } state_t;

  state_t      state_q;
  logic [95:0] codes_q;
  logic [7:0]  gap_q;
  logic [15:0] tmo_q;
  logic        spi_start_q;
  logic [31:0] spi_data_q;
  logic        busy_q;
  logic        cfg_done_q;
  logic        err_q;
  logic [3:0]  word_idx_q;

  logic [2:0]  ch;
  logic [6:0]  base;
  logic [31:0] word_d;

  // Table lookup: idx 2..9 map to channel writes from the latched codes.
  always_comb begin
    ch     = 3'(word_idx_q - 4'd2);
    base   = 7'(ch) * 7'd12;
    word_d = {8'h03, 1'b0, ch, codes_q[base +: 12], 8'h00};
    unique case (word_idx_q)
      4'd0:    word_d = 32'h0700_0000;
      4'd1:    word_d = 32'h0800_0001;
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      state_q     <= S_IDLE;
      codes_q     <= '0;
      gap_q       <= '0;
      tmo_q       <= '0;
      spi_start_q <= 1'b0;
      spi_data_q  <= '0;
      busy_q      <= 1'b0;
      cfg_done_q  <= 1'b0;
      err_q       <= 1'b0;
      word_idx_q  <= '0;
    end else begin
      spi_start_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            cfg_done_q <= 1'b0;
            err_q      <= 1'b0;
            codes_q    <= ch_codes;
            word_idx_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= S_LOAD;
          end
        end
        S_LOAD: begin
          spi_data_q <= word_d;
          state_q    <= S_ISSUE;
        end
        S_ISSUE: begin
          if (!spi_busy) begin
            spi_start_q <= 1'b1;
            tmo_q       <= '0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A done arriving on the limit cycle wins over the timeout.
          if (spi_done) begin
            gap_q   <= '0;
            state_q <= S_GAP;
          end else if (tmo_q == TMO_LIM) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            if (word_idx_q == 4'd9) begin
              state_q <= S_FINISH;
            end else begin
              word_idx_q <= word_idx_q + 4'd1;
              state_q    <= S_LOAD;
            end
          end else begin
            gap_q <= gap_q + 8'd1;
          end
        end
        S_FINISH: begin
          cfg_done_q <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign spi_start = spi_start_q;
  assign spi_data  = spi_data_q;
  assign busy      = busy_q;
  assign cfg_done  = cfg_done_q;
  assign err       = err_q;
  assign word_idx  = word_idx_q;

endmodule

// File: tb/tb_ad5628_cfg_seq.sv
// tb_ad5628_cfg_seq: scoreboard bench for the AD5628 config sequencer.
// A shifter model answers spi_start; a monitor pops expected words.
module tb_ad5628_cfg_seq;

  localparam int GAP = 4;
  localparam int TMO = 1024;
  localparam int DLY = 64;

  logic        clk_sys;
  logic        rst_sys;
  logic        start;
  logic [95:0] ch_codes;
  logic        spi_busy;
  logic        spi_done;
  logic        spi_start;
  logic [31:0] spi_data;
  logic        busy;
  logic        cfg_done;
  logic        err;
  logic [3:0]  word_idx;

  ad5628_cfg_seq #(
    .GAP_CYCLES(GAP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_sys(clk_sys),
    .rst_sys(rst_sys),
    .start(start),
    .ch_codes(ch_codes),
    .spi_busy(spi_busy),
    .spi_done(spi_done),
    .spi_start(spi_start),
    .spi_data(spi_data),
    .busy(busy),
    .cfg_done(cfg_done),
    .err(err),
    .word_idx(word_idx)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_starts = 0;
  int last_start = 0;
  int done_edge = 0;
  int stall_idx = -1;
  bit done_valid = 0;
  bit gap_chk = 1;
  logic [31:0] exp_q[$];
  logic [31:0] got[10];

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  always @(posedge clk_sys) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  function automatic logic [31:0] exp_word(input int idx, input logic [95:0] c);
    logic [3:0] n;
    if (idx == 0) return 32'h0700_0000;
    if (idx == 1) return 32'h0800_0001;
    n = 4'(idx - 2);
    return {4'h0, 4'h3, n, c[(idx-2)*12 +: 12], 8'h00};
  endfunction

  function automatic logic [95:0] mk_codes(input int mode);
    logic [95:0] c;
    for (int n = 0; n < 8; n++) begin
      if (mode == 0) c[n*12 +: 12] = 12'h800;
      else if (mode == 1) c[n*12 +: 12] = 12'(n * 257);
      else c[n*12 +: 12] = 12'($urandom_range(0, 4095));
    end
    return c;
  endfunction

  // Shifter model: done pulse sampled DLY edges after the start pulse.
  initial begin : shifter
    int cnt;
    cnt = 0;
    spi_done = 1'b0;
    forever begin
      @(negedge clk_sys);
      spi_done = 1'b0;
      if (rst_sys) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            spi_done = 1'b1;
            done_edge = cyc + 1;
            done_valid = 1'b1;
          end
        end
        if (spi_start === 1'b1 && int'(word_idx) != stall_idx) cnt = DLY;
      end
    end
  end

  initial begin : monitor
    logic [31:0] w;
    forever begin
      @(negedge clk_sys);
      if (spi_start === 1'b1) begin
        n_starts++;
        last_start = cyc;
        if (word_idx < 4'd10) got[word_idx] = spi_data;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_start: idx=%0d data=%h, required no pulse",
                   word_idx, spi_data);
        end else begin
          w = exp_q.pop_front();
          if (spi_data !== w) begin
            errors++;
            $display("FAIL word_data: idx=%0d got %h, required %h",
                     word_idx, spi_data, w);
          end
        end
        if (gap_chk && done_valid) begin
          checks++;
          if (cyc - done_edge != GAP + 2) begin
            errors++;
            $display("FAIL word_gap: got %0d cycles, required %0d",
                     cyc - done_edge, GAP + 2);
          end
        end
      end
    end
  end

  task automatic push_run(input logic [95:0] c, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(exp_word(i, c));
  endtask

  task automatic start_run(input logic [95:0] c);
    @(negedge clk_sys);
    done_valid = 1'b0;
    n_starts = 0;
    ch_codes = c;
    start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    ch_codes = ~c;
    checks++;
    if ({busy, cfg_done, err} !== 3'b100) begin
      errors++;
      $display("FAIL start_accept: busy/cfg_done/err=%b, required 100",
               {busy, cfg_done, err});
    end
    @(negedge clk_sys);
    checks++;
    if (spi_data !== 32'h0700_0000) begin
      errors++;
      $display("FAIL first_data: got %h, required 07000000", spi_data);
    end
    @(negedge clk_sys);
    checks++;
    if (spi_start !== 1'b1) begin
      errors++;
      $display("FAIL first_start: got %b, required 1", spi_start);
    end
  endtask

  task automatic wait_end(input int budget);
    int k;
    k = 0;
    while (cfg_done !== 1'b1 && err !== 1'b1 && k < budget) begin
      @(negedge clk_sys);
      k++;
    end
    checks++;
    if (k >= budget) begin
      errors++;
      $display("FAIL end_wait: cfg_done=%b err=%b after %0d cycles, required end",
               cfg_done, err, k);
    end
  endtask

  task automatic wait_idx(input logic [3:0] v, input int budget);
    int k;
    k = 0;
    while (word_idx !== v && k < budget) begin
      @(negedge clk_sys);
      k++;
    end
    checks++;
    if (k >= budget) begin
      errors++;
      $display("FAIL idx_wait: word_idx=%0d, required %0d", word_idx, v);
    end
  endtask

  task automatic check_done_ok(input int nwant);
    checks++;
    if ({cfg_done, err, busy} !== 3'b100) begin
      errors++;
      $display("FAIL end_state: cfg_done/err/busy=%b, required 100",
               {cfg_done, err, busy});
    end
    checks++;
    if (n_starts != nwant || exp_q.size() != 0) begin
      errors++;
      $display("FAIL start_count: got %0d (left %0d), required %0d (left 0)",
               n_starts, exp_q.size(), nwant);
    end
  endtask

  task automatic test_reset();
    rst_sys = 1'b1;
    start = 1'b0;
    spi_busy = 1'b0;
    ch_codes = '0;
    repeat (3) @(negedge clk_sys);
    checks++;
    if ({spi_start, spi_data, busy, cfg_done, err, word_idx} !== '0) begin
      errors++;
      $display("FAIL reset_hold: outputs=%h, required 0",
               {spi_start, spi_data, busy, cfg_done, err, word_idx});
    end
    rst_sys = 1'b0;
    repeat (3) @(negedge clk_sys);
    checks++;
    if ({spi_start, spi_data, busy, cfg_done, err, word_idx} !== '0) begin
      errors++;
      $display("FAIL reset_idle: outputs=%h, required 0",
               {spi_start, spi_data, busy, cfg_done, err, word_idx});
    end
  endtask

  task automatic test_nominal();
    logic [95:0] c;
    c = mk_codes(0);
    push_run(c, 10);
    start_run(c);
    wait_end(2000);
    checks++;
    if (cyc - done_edge != GAP + 1) begin
      errors++;
      $display("FAIL done_timing: got %0d, required %0d", cyc - done_edge, GAP + 1);
    end
    check_done_ok(10);
  endtask

  task automatic test_distinct();
    logic [95:0] c;
    c = mk_codes(1);
    push_run(c, 10);
    start_run(c);
    wait_end(2000);
    check_done_ok(10);
    checks++;
    if (got[5] !== 32'h0333_0300) begin
      errors++;
      $display("FAIL word5: got %h, required 03330300", got[5]);
    end
  endtask

  task automatic test_start_busy();
    logic [95:0] a;
    logic [95:0] b;
    a = mk_codes(2);
    b = mk_codes(2);
    push_run(a, 10);
    start_run(a);
    wait_idx(4'd4, 2000);
    ch_codes = b;
    start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    wait_end(2000);
    check_done_ok(10);
    push_run(b, 10);
    start_run(b);
    wait_end(2000);
    check_done_ok(10);
  endtask

  task automatic test_timeout();
    logic [95:0] c;
    c = mk_codes(2);
    stall_idx = 2;
    push_run(c, 3);
    start_run(c);
    wait_end(3000);
    checks++;
    if (cyc - last_start != TMO + 1) begin
      errors++;
      $display("FAIL tmo_timing: got %0d edges, required %0d",
               cyc - last_start, TMO + 1);
    end
    checks++;
    if ({err, busy, cfg_done} !== 3'b100) begin
      errors++;
      $display("FAIL tmo_state: err/busy/cfg_done=%b, required 100",
               {err, busy, cfg_done});
    end
    checks++;
    if (n_starts != 3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL tmo_starts: got %0d, required 3", n_starts);
    end
    stall_idx = -1;
    push_run(c, 10);
    start_run(c);
    wait_end(2000);
    check_done_ok(10);
  endtask

  task automatic test_backpressure();
    logic [95:0] c;
    int bad;
    c = mk_codes(2);
    push_run(c, 10);
    start_run(c);
    wait_idx(4'd4, 2000);
    gap_chk = 1'b0;
    @(negedge clk_sys);
    spi_busy = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk_sys);
      if (spi_start !== 1'b0) bad++;
    end
    spi_busy = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: got %0d pulses while busy, required 0", bad);
    end
    @(negedge clk_sys);
    checks++;
    if (spi_start !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got %b, required 1", spi_start);
    end
    @(negedge clk_sys);
    checks++;
    if (spi_start !== 1'b0) begin
      errors++;
      $display("FAIL bp_single: got %b, required 0", spi_start);
    end
    gap_chk = 1'b1;
    wait_end(2000);
    check_done_ok(10);
  endtask

  task automatic test_reset_mid();
    logic [95:0] c;
    int s0;
    c = mk_codes(2);
    push_run(c, 10);
    start_run(c);
    wait_idx(4'd6, 2000);
    repeat (10) @(negedge clk_sys);
    #3 rst_sys = 1'b1;
    #1;
    checks++;
    if ({spi_start, spi_data, busy, cfg_done, err, word_idx} !== '0) begin
      errors++;
      $display("FAIL rst_async: outputs=%h, required 0",
               {spi_start, spi_data, busy, cfg_done, err, word_idx});
    end
    repeat (2) @(negedge clk_sys);
    rst_sys = 1'b0;
    exp_q.delete();
    s0 = n_starts;
    repeat (150) @(negedge clk_sys);
    checks++;
    if (n_starts != s0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_quiet: starts %0d busy %b, required %0d and 0",
               n_starts, busy, s0);
    end
    push_run(c, 10);
    start_run(c);
    wait_end(2000);
    check_done_ok(10);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_distinct();
    test_start_busy();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    repeat (5) @(negedge clk_sys);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
